// File: rtl/sram_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_bus_pkg
// Brief    : Shared constants and FSM encodings for the SRAM bus responder.
// Revision : 1.0
// ============================================================================
package sram_bus_pkg;

    localparam int SRAM_DATA_W     = 8;
    localparam int SYNC_STAGES_DEF = 2;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_READ_ENC  = 2'd1;
    localparam logic [1:0] ST_WRITE_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_READ  = ST_READ_ENC,
        ST_WRITE = ST_WRITE_ENC
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sram_resp_sync.sv
`default_nettype none
// ============================================================================
// Module   : sram_resp_sync
// Brief    : STAGES-deep synchronizer for an active-low bus strobe, resets to 1.
// Revision : 1.0
// ============================================================================
module sram_resp_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_async,
    output logic o_sync
);

    localparam int DEPTH = (STAGES < 2) ? 2 : STAGES;

    logic [DEPTH-1:0] r_chain;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_chain <= '1;
        end else begin
            r_chain <= {r_chain[DEPTH-2:0], i_async};
        end
    end

    assign o_sync = r_chain[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/sram_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : sram_bus_responder
// Brief    : Async SRAM bus target backed by internal block RAM.
//            Define SRAM_RESP_STATS_EN to add wr_cnt/rd_cnt statistics outputs.
// Revision : 1.0
// ============================================================================
module sram_bus_responder
    import sram_bus_pkg::*;
#(
    parameter int ADDR_W      = 11,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [ADDR_W-1:0]      bus_addr,
    input  logic                   bus_ce_n,
    input  logic                   bus_we_n,
    input  logic                   bus_oe_n,
    input  logic [SRAM_DATA_W-1:0] bus_din,
    output logic [SRAM_DATA_W-1:0] bus_dout,
    output logic                   bus_oe,
    output logic                   wr_stb,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [SRAM_DATA_W-1:0] wr_data
`ifdef SRAM_RESP_STATS_EN
    ,
    output logic [15:0]            wr_cnt,
    output logic [15:0]            rd_cnt
`endif
);

    localparam int DEPTH = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic w_ce_s, w_we_s, w_oe_s;

    sram_resp_sync #(.STAGES(DEPTH)) u_sync_ce (
        .clk(clk), .reset_n(reset_n), .i_async(bus_ce_n), .o_sync(w_ce_s));
    sram_resp_sync #(.STAGES(DEPTH)) u_sync_we (
        .clk(clk), .reset_n(reset_n), .i_async(bus_we_n), .o_sync(w_we_s));
    sram_resp_sync #(.STAGES(DEPTH)) u_sync_oe (
        .clk(clk), .reset_n(reset_n), .i_async(bus_oe_n), .o_sync(w_oe_s));

    // Address/data delayed by the same depth so they line up with the strobes
    logic [ADDR_W-1:0]      r_addr_pipe [DEPTH];
    logic [SRAM_DATA_W-1:0] r_data_pipe [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_addr_pipe[i] <= '0;
                r_data_pipe[i] <= '0;
            end
        end else begin
            r_addr_pipe[0] <= bus_addr;
            r_data_pipe[0] <= bus_din;
            for (int i = 1; i < DEPTH; i++) begin
                r_addr_pipe[i] <= r_addr_pipe[i-1];
                r_data_pipe[i] <= r_data_pipe[i-1];
            end
        end
    end

    logic [ADDR_W-1:0]      w_addr_p;
    logic [SRAM_DATA_W-1:0] w_data_p;
    assign w_addr_p = r_addr_pipe[DEPTH-1];
    assign w_data_p = r_data_pipe[DEPTH-1];

    state_t r_state, w_state_nxt;
    logic   w_wr_latch, w_wr_commit, w_rd_drive, w_rd_enter;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wr_latch  = 1'b0;
        w_wr_commit = 1'b0;
        w_rd_drive  = 1'b0;
        w_rd_enter  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_ce_s && !w_we_s) begin
                    w_state_nxt = ST_WRITE;
                end else if (!w_ce_s && !w_oe_s) begin
                    w_state_nxt = ST_READ;
                    w_rd_enter  = 1'b1;
                end
            end
            ST_WRITE: begin
                if (w_ce_s || w_we_s) begin
                    w_wr_commit = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_wr_latch  = 1'b1;
                end
            end
            ST_READ: begin
                if (w_ce_s || w_oe_s)  w_state_nxt = ST_IDLE;
                else if (!w_we_s)      w_state_nxt = ST_WRITE;
                else                   w_rd_drive  = 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Single-port RAM: the commit cycle borrows the port for the latched address
    logic [SRAM_DATA_W-1:0] r_mem [2**ADDR_W];
    logic [SRAM_DATA_W-1:0] r_ram_q;
    logic [ADDR_W-1:0]      r_lat_addr;
    logic [SRAM_DATA_W-1:0] r_lat_data;
    logic [ADDR_W-1:0]      w_ram_addr;

    assign w_ram_addr = w_wr_commit ? r_lat_addr : w_addr_p;

    always_ff @(posedge clk) begin
        if (w_wr_commit) r_mem[w_ram_addr] <= r_lat_data;
        r_ram_q <= r_mem[w_ram_addr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lat_addr <= '0;
            r_lat_data <= '0;
            wr_stb     <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            bus_oe     <= 1'b0;
            bus_dout   <= '0;
        end else begin
            if (w_wr_latch) begin
                r_lat_addr <= w_addr_p;
                r_lat_data <= w_data_p;
            end
            wr_stb <= w_wr_commit;
            if (w_wr_commit) begin
                wr_addr <= r_lat_addr;
                wr_data <= r_lat_data;
            end
            bus_oe <= w_rd_drive;
            if (w_rd_drive) bus_dout <= r_ram_q;
        end
    end

`ifdef SRAM_RESP_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (wr_stb)     wr_cnt <= wr_cnt + 16'd1;
            if (w_rd_enter) rd_cnt <= rd_cnt + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire
